// File: rtl/poca_pkg.sv
// Shared definitions for the POCA multi-channel cycle timer.
//   timer_state_t : per-channel FSM state (IDLE, ARMED, RUN, DONE)
//   TIMER_STATE_W : encoding width of timer_state_t
package poca_pkg;

  localparam int unsigned TIMER_STATE_W = 2;

  typedef enum logic [TIMER_STATE_W-1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } timer_state_t;

endpackage

// File: rtl/poca_timer_ch.sv
// One channel of the POCA cycle down-counter.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cnt_load     : pulse, count = reload = cycle, go ARMED
//   cycle        : load value (WIDTH bits)
//   cnt_start    : pulse, ARMED -> RUN, or DONE -> RUN with count reloaded
//   cnt_hold     : level, freezes the count while in RUN
//   cnt_abort    : pulse, go IDLE with count and flags cleared
//   auto_reload  : level, sampled at terminal count
//   done_ack     : pulse, clears cnt_done / cnt_ovf
//   cnt_done     : sticky terminal flag
//   done_pulse   : one cycle high after each terminal event
//   cnt_ovf      : sticky, terminal event seen while cnt_done already set
//   cnt_busy     : channel is in RUN
//   cnt_val      : current count
module poca_timer_ch
  import poca_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_load,
  input  logic [WIDTH-1:0] cycle,
  input  logic             cnt_start,
  input  logic             cnt_hold,
  input  logic             cnt_abort,
  input  logic             auto_reload,
  input  logic             done_ack,
  output logic             cnt_done,
  output logic             done_pulse,
  output logic             cnt_ovf,
  output logic             cnt_busy,
  output logic [WIDTH-1:0] cnt_val
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    terminal = 1'b0;

    if (cnt_abort) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (cnt_load) begin
      state_d  = ARMED;
      count_d  = cycle;
      reload_d = cycle;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      // Ack is applied first so a same-cycle terminal event overrides it;
      // overrun still looks at the registered (pre-ack) done flag.
      if (done_ack) begin
        done_d = 1'b0;
        ovf_d  = 1'b0;
      end
      case (state_q)
        ARMED: if (cnt_start) state_d = RUN;
        DONE: begin
          if (cnt_start) begin
            count_d = reload_q;
            done_d  = 1'b0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!cnt_hold) begin
            // A count of 0 is not terminal: it wraps to all-ones, giving 2^WIDTH cycles.
            if (count_q == WIDTH'(1)) terminal = 1'b1;
            else                      count_d  = count_q - WIDTH'(1);
          end
        end
        default: ;
      endcase
      if (terminal) begin
        done_d = 1'b1;
        if (done_q) ovf_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  assign pulse_d    = terminal;
  assign cnt_done   = done_q;
  assign done_pulse = pulse_q;
  assign cnt_ovf    = ovf_q;
  assign cnt_busy   = (state_q == RUN);
  assign cnt_val    = count_q;

endmodule

// File: rtl/poca_multi_timer.sv
// NCH independent POCA cycle down-counters. Bit / slice i of every vector
// belongs to channel i; multi-bit slices are [i*WIDTH +: WIDTH].
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   cnt_load, cnt_start, cnt_abort   : per-channel command pulses
//   cnt_hold, auto_reload            : per-channel levels
//   done_ack                         : per-channel flag clear
//   cycle                            : per-channel load values
//   cnt_done, done_pulse, cnt_ovf    : per-channel status flags
//   cnt_busy                         : per-channel RUN indicator
//   cnt_val                          : per-channel current count
module poca_multi_timer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       cnt_load,
  input  logic [NCH*WIDTH-1:0] cycle,
  input  logic [NCH-1:0]       cnt_start,
  input  logic [NCH-1:0]       cnt_hold,
  input  logic [NCH-1:0]       cnt_abort,
  input  logic [NCH-1:0]       auto_reload,
  input  logic [NCH-1:0]       done_ack,
  output logic [NCH-1:0]       cnt_done,
  output logic [NCH-1:0]       done_pulse,
  output logic [NCH-1:0]       cnt_ovf,
  output logic [NCH-1:0]       cnt_busy,
  output logic [NCH*WIDTH-1:0] cnt_val
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    poca_timer_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cnt_load   (cnt_load[g]),
      .cycle      (cycle[g*WIDTH +: WIDTH]),
      .cnt_start  (cnt_start[g]),
      .cnt_hold   (cnt_hold[g]),
      .cnt_abort  (cnt_abort[g]),
      .auto_reload(auto_reload[g]),
      .done_ack   (done_ack[g]),
      .cnt_done   (cnt_done[g]),
      .done_pulse (done_pulse[g]),
      .cnt_ovf    (cnt_ovf[g]),
      .cnt_busy   (cnt_busy[g]),
      .cnt_val    (cnt_val[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_poca_multi_timer.sv
// Self-checking bench for poca_multi_timer: a 32-bit 4-channel instance (a_*)
// and a 4-bit 2-channel instance (b_*) for the wrap boundary. Model channels
// 0..3 map to instance a, 4..5 to instance b.
module tb_poca_multi_timer;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]   a_load, a_start, a_hold, a_abort, a_ar, a_ack;
  logic [127:0] a_cycle, a_val;
  logic [3:0]   a_done, a_pulse, a_ovf, a_busy;

  logic [1:0]   b_load, b_start, b_hold, b_abort, b_ar, b_ack;
  logic [7:0]   b_cycle, b_val;
  logic [1:0]   b_done, b_pulse, b_ovf, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  poca_multi_timer #(.WIDTH(32), .NCH(4)) dut_a (
    .clk(clk), .rst(rst), .cnt_load(a_load), .cycle(a_cycle), .cnt_start(a_start),
    .cnt_hold(a_hold), .cnt_abort(a_abort), .auto_reload(a_ar), .done_ack(a_ack),
    .cnt_done(a_done), .done_pulse(a_pulse), .cnt_ovf(a_ovf), .cnt_busy(a_busy),
    .cnt_val(a_val)
  );

  poca_multi_timer #(.WIDTH(4), .NCH(2)) dut_b (
    .clk(clk), .rst(rst), .cnt_load(b_load), .cycle(b_cycle), .cnt_start(b_start),
    .cnt_hold(b_hold), .cnt_abort(b_abort), .auto_reload(b_ar), .done_ack(b_ack),
    .cnt_done(b_done), .done_pulse(b_pulse), .cnt_ovf(b_ovf), .cnt_busy(b_busy),
    .cnt_val(b_val)
  );

  // Reference model: plain arithmetic on the remaining count per channel.
  typedef enum int {M_IDLE, M_ARMED, M_RUN, M_DONE} mph_t;
  mph_t            m_ph[6];
  longint unsigned m_cnt[6], m_rel[6];
  bit              m_done[6], m_pulse[6], m_ovf[6];

  task automatic model_reset();
    for (int c = 0; c < 6; c++) begin
      m_ph[c] = M_IDLE; m_cnt[c] = 0; m_rel[c] = 0;
      m_done[c] = 0; m_pulse[c] = 0; m_ovf[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 6; c++) begin
      bit ld, st, hd, ab, ar, ak, term, prev_done;
      longint unsigned cyc, modv;
      if (c < 4) begin
        ld = a_load[c]; st = a_start[c]; hd = a_hold[c]; ab = a_abort[c];
        ar = a_ar[c]; ak = a_ack[c]; cyc = a_cycle[c*32 +: 32]; modv = 64'h1_0000_0000;
      end else begin
        ld = b_load[c-4]; st = b_start[c-4]; hd = b_hold[c-4]; ab = b_abort[c-4];
        ar = b_ar[c-4]; ak = b_ack[c-4]; cyc = b_cycle[(c-4)*4 +: 4]; modv = 16;
      end
      term = 0;
      prev_done = m_done[c];
      m_pulse[c] = 0;
      if (ab) begin
        m_ph[c] = M_IDLE; m_cnt[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
      end else if (ld) begin
        m_ph[c] = M_ARMED; m_cnt[c] = cyc; m_rel[c] = cyc; m_done[c] = 0; m_ovf[c] = 0;
      end else begin
        if (ak) begin m_done[c] = 0; m_ovf[c] = 0; end
        if (st && m_ph[c] == M_ARMED) m_ph[c] = M_RUN;
        else if (st && m_ph[c] == M_DONE) begin
          m_cnt[c] = m_rel[c]; m_done[c] = 0; m_ph[c] = M_RUN;
        end else if (m_ph[c] == M_RUN && !hd) begin
          if (m_cnt[c] == 1) term = 1;
          else m_cnt[c] = (m_cnt[c] + modv - 1) % modv;
        end
      end
      if (term) begin
        m_done[c] = 1; m_pulse[c] = 1;
        if (prev_done) m_ovf[c] = 1;
        if (ar) m_cnt[c] = m_rel[c];
        else begin m_cnt[c] = 0; m_ph[c] = M_DONE; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0]   ed, ep, eo, eb;
    logic [127:0] ev;
    logic [1:0]   fd, fp, fo, fb;
    logic [7:0]   fv;
    for (int c = 0; c < 4; c++) begin
      ed[c] = m_done[c]; ep[c] = m_pulse[c]; eo[c] = m_ovf[c];
      eb[c] = (m_ph[c] == M_RUN); ev[c*32 +: 32] = m_cnt[c][31:0];
    end
    for (int c = 0; c < 2; c++) begin
      fd[c] = m_done[c+4]; fp[c] = m_pulse[c+4]; fo[c] = m_ovf[c+4];
      fb[c] = (m_ph[c+4] == M_RUN); fv[c*4 +: 4] = m_cnt[c+4][3:0];
    end
    chk({tag, ".a_done"},  a_done,  ed);
    chk({tag, ".a_pulse"}, a_pulse, ep);
    chk({tag, ".a_ovf"},   a_ovf,   eo);
    chk({tag, ".a_busy"},  a_busy,  eb);
    chk({tag, ".a_val"},   a_val,   ev);
    chk({tag, ".b_done"},  b_done,  fd);
    chk({tag, ".b_pulse"}, b_pulse, fp);
    chk({tag, ".b_ovf"},   b_ovf,   fo);
    chk({tag, ".b_busy"},  b_busy,  fb);
    chk({tag, ".b_val"},   b_val,   fv);
  endtask

  // One clock: model consumes the current inputs, DUT sampled 1 time unit after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    a_load = '0; a_start = '0; a_abort = '0; a_ack = '0;
    b_load = '0; b_start = '0; b_abort = '0; b_ack = '0;
  endtask

  task automatic clear_inputs();
    a_load = '0; a_start = '0; a_hold = '0; a_abort = '0; a_ar = '0; a_ack = '0; a_cycle = '0;
    b_load = '0; b_start = '0; b_hold = '0; b_abort = '0; b_ar = '0; b_ack = '0; b_cycle = '0;
  endtask

  initial begin
    bit found;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    check_all("reset");
    #1 rst = 1'b0;

    // One-shot latency, N=5 on ch0, then restart from DONE.
    a_cycle[31:0] = 32'd5; a_load[0] = 1'b1; tick("os_load");
    a_start[0] = 1'b1; tick("os_start");
    chk("os_busy_e0", a_busy[0], 1'b1);
    repeat (4) tick("os_run");
    chk("os_not_done_e4", a_done[0], 1'b0);
    tick("os_term");
    chk("os_done_e5", a_done[0], 1'b1);
    chk("os_pulse_e5", a_pulse[0], 1'b1);
    chk("os_val_e5", a_val[31:0], 32'd0);
    tick("os_after");
    chk("os_pulse_gone", a_pulse[0], 1'b0);
    chk("os_idle_busy", a_busy[0], 1'b0);
    a_start[0] = 1'b1; tick("os_restart");
    repeat (4) tick("os_rerun");
    chk("os_re_not_done", a_done[0], 1'b0);
    tick("os_reterm");
    chk("os_re_done", a_done[0], 1'b1);

    // Hold for 3 cycles on ch1, N=10: terminal at 13 edges after start.
    a_cycle[63:32] = 32'd10; a_load[1] = 1'b1; tick("hold_load");
    a_start[1] = 1'b1; tick("hold_start");
    repeat (2) tick("hold_run");
    a_hold[1] = 1'b1; repeat (3) tick("hold_frozen");
    a_hold[1] = 1'b0; repeat (7) tick("hold_run2");
    chk("hold_not_done_e12", a_done[1], 1'b0);
    tick("hold_term");
    chk("hold_done_e13", a_done[1], 1'b1);

    // Abort ch1 when its count reaches 4.
    a_load[1] = 1'b1; tick("ab_load");
    a_start[1] = 1'b1; tick("ab_start");
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt[1] == 4) found = 1;
      else tick("ab_run");
    end
    chk("ab_reached_4", a_val[63:32], 32'd4);
    a_abort[1] = 1'b1; tick("ab_abort");
    chk("ab_busy", a_busy[1], 1'b0);
    chk("ab_val", a_val[63:32], 32'd0);
    repeat (4) tick("ab_quiet");
    chk("ab_no_pulse", a_pulse[1], 1'b0);
    chk("ab_no_done", a_done[1], 1'b0);

    // Auto-reload N=3 on ch2, no ack.
    a_ar[2] = 1'b1; a_cycle[95:64] = 32'd3; a_load[2] = 1'b1; tick("ar_load");
    a_start[2] = 1'b1; tick("ar_start");
    repeat (3) tick("ar_run1");
    chk("ar_pulse1", a_pulse[2], 1'b1);
    chk("ar_ovf1", a_ovf[2], 1'b0);
    repeat (3) tick("ar_run2");
    chk("ar_pulse2", a_pulse[2], 1'b1);
    chk("ar_ovf2", a_ovf[2], 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_cnt[2] == 1) found = 1;
      else tick("ar_seek");
    end
    chk("ar_seek_term", a_val[95:64], 32'd1);
    a_ack[2] = 1'b1; tick("ar_ack_term");
    chk("ar_ack_term_done", a_done[2], 1'b1);
    a_ack[2] = 1'b1; tick("ar_ack_plain");
    chk("ar_ack_plain_done", a_done[2], 1'b0);
    chk("ar_ack_plain_ovf", a_ovf[2], 1'b0);
    a_ar[2] = 1'b0; a_abort[2] = 1'b1; tick("ar_abort");

    // Wrap on the 4-bit instance: load 0 runs 16 cycles.
    b_cycle[3:0] = 4'd0; b_load[0] = 1'b1; tick("wrap_load");
    b_start[0] = 1'b1; tick("wrap_start");
    chk("wrap_val_e0", b_val[3:0], 4'd0);
    tick("wrap_e1");
    chk("wrap_val_e1", b_val[3:0], 4'd15);
    repeat (14) tick("wrap_run");
    chk("wrap_val_e15", b_val[3:0], 4'd1);
    chk("wrap_not_done", b_done[0], 1'b0);
    tick("wrap_term");
    chk("wrap_done", b_done[0], 1'b1);
    chk("wrap_val_end", b_val[3:0], 4'd0);

    // Independence: 2, 7, 1, 4 started together.
    a_cycle = {32'd4, 32'd1, 32'd7, 32'd2};
    a_load = 4'hF; tick("ind_load");
    a_start = 4'hF; tick("ind_start");
    tick("ind_e1");
    chk("ind_e1", a_done, 4'b0100);
    tick("ind_e2");
    chk("ind_e2", a_done, 4'b0101);
    repeat (2) tick("ind_e34");
    chk("ind_e4", a_done, 4'b1101);
    repeat (3) tick("ind_e57");
    chk("ind_e7", a_done, 4'b1111);

    // Load and abort together: abort wins.
    a_cycle[127:96] = 32'd9; a_load[3] = 1'b1; a_abort[3] = 1'b1; tick("la_both");
    chk("la_val", a_val[127:96], 32'd0);
    a_start[3] = 1'b1; tick("la_start");
    chk("la_busy", a_busy[3], 1'b0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        a_load[c]  = ($urandom_range(0, 19) == 0);
        a_start[c] = ($urandom_range(0, 4) == 0);
        a_hold[c]  = ($urandom_range(0, 3) == 0);
        a_abort[c] = ($urandom_range(0, 39) == 0);
        a_ack[c]   = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) a_ar[c] = ~a_ar[c];
        a_cycle[c*32 +: 32] = 32'($urandom_range(0, 9));
      end
      for (int c = 0; c < 2; c++) begin
        b_load[c]  = ($urandom_range(0, 19) == 0);
        b_start[c] = ($urandom_range(0, 4) == 0);
        b_hold[c]  = ($urandom_range(0, 3) == 0);
        b_abort[c] = ($urandom_range(0, 39) == 0);
        b_ack[c]   = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) b_ar[c] = ~b_ar[c];
        b_cycle[c*4 +: 4] = 4'($urandom);
      end
      tick("rand");
    end
    clear_inputs();
    tick("rand_settle");

    // Reset asserted mid-run, then a start without a new load.
    a_cycle[31:0] = 32'd20; a_load[0] = 1'b1; tick("rst_load");
    a_start[0] = 1'b1; tick("rst_start");
    repeat (3) tick("rst_run");
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", a_busy, 4'b0);
    chk("rst_done", a_done, 4'b0);
    chk("rst_val", a_val, 128'b0);
    chk("rst_b_val", b_val, 8'b0);
    model_reset();
    #1 rst = 1'b0;
    a_start[0] = 1'b1; tick("rst_restart");
    chk("rst_start_ignored", a_busy[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
